// File: rtl/fetch_instruction.sv
// Instruction fetch stage for the 16-bit WISC datapath: PC register, one-outstanding imem fetch,
// registered decode buffer, redirect/halt handling. Optional macro: FETCH_ALIGN_CHK_EN.
module fetch_instruction #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_next_pc,
    output logic        halted,
    output logic        err
);

    localparam int unsigned XLEN = 16;
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(2);
`ifdef FETCH_ALIGN_CHK_EN
    localparam logic [XLEN-1:0] PC_MASK = '1;
`else
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(1);
`endif

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            squash_q, squash_d;
    logic            halt_pend_q, halt_pend_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_npc_q, if_npc_d;
    logic            req_fire_c;
    logic            misalign_c;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d;
    assign misalign_c = pc_q[0];
    assign err        = err_q;
`else
    assign misalign_c = 1'b0;
    assign err        = 1'b0;
`endif

    // Issue only when the buffer will be empty by the time the word returns
    assign imem_req_valid = rst_n && (state_q == ST_FETCH) && !misalign_c && (!if_valid_q || id_ready);
    assign imem_addr      = pc_q;
    assign req_fire_c     = imem_req_valid && imem_req_ready;

    assign if_valid   = if_valid_q;
    assign if_instr   = instr_q;
    assign if_pc      = if_pc_q;
    assign if_next_pc = if_npc_q;
    assign halted     = (state_q == ST_HALTED);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        halt_pend_d = halt_pend_q;
        if_valid_d  = if_valid_q && !id_ready;
        instr_d     = instr_q;
        if_pc_d     = if_pc_q;
        if_npc_d    = if_npc_q;
`ifdef FETCH_ALIGN_CHK_EN
        err_d       = err_q;
`endif

        case (state_q)
            ST_FETCH: begin
                if (misalign_c) begin
`ifdef FETCH_ALIGN_CHK_EN
                    err_d   = 1'b1;
`endif
                    state_d = ST_HALTED;
                end else if (req_fire_c) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    squash_d = 1'b0;
                    state_d  = halt_pend_q ? ST_HALTED : ST_FETCH;
                    if (!squash_q) begin
                        if_valid_d = 1'b1;
                        instr_d    = imem_rsp_data;
                        if_pc_d    = pc_q;
                        if_npc_d   = pc_q + PC_STEP;
                        pc_d       = pc_q + PC_STEP;
                    end
                end
            end
            default: ;
        endcase

        // Redirect beats halt; both flush the buffer and kill any word still in flight
        if (state_q != ST_HALTED) begin
            if (redirect_valid) begin
                pc_d       = redirect_pc & PC_MASK;
                if_valid_d = 1'b0;
                if ((state_q == ST_FETCH && req_fire_c) || (state_q == ST_WAIT && !imem_rsp_valid)) begin
                    squash_d = 1'b1;
                end
            end else if (halt) begin
                if_valid_d  = 1'b0;
                halt_pend_d = 1'b1;
                if (state_q == ST_FETCH) begin
                    if (req_fire_c) begin
                        state_d  = ST_WAIT;
                        squash_d = 1'b1;
                    end else begin
                        state_d  = ST_HALTED;
                    end
                end else if (state_q == ST_WAIT) begin
                    if (imem_rsp_valid) begin
                        state_d  = ST_HALTED;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
            end
        end

        if (!if_valid_d) begin
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC & PC_MASK;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            if_valid_q  <= 1'b0;
            instr_q     <= NOP_INSTR;
            if_pc_q     <= '0;
            if_npc_q    <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            halt_pend_q <= halt_pend_d;
            if_valid_q  <= if_valid_d;
            instr_q     <= instr_d;
            if_pc_q     <= if_pc_d;
            if_npc_q    <= if_npc_d;
`ifdef FETCH_ALIGN_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_instruction.sv
// Directed self-checking bench for fetch_instruction with a variable-latency instruction memory model.
module tb_fetch_instruction;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        if_valid;
    logic        id_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_next_pc;
    logic        halted;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    int          mem_lat;
    int          mem_cnt;
    logic        mem_pend;
    logic [15:0] mem_addr_l;
    int          acc_cnt;
    logic        saw_odd;

    fetch_instruction dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_next_pc     (if_next_pc),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Instruction memory: response mem_lat cycles after acceptance, one request at a time
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend       <= 1'b0;
            mem_cnt        <= 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 16'h0000;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(mem_addr_l);
                    mem_pend       <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt <= acc_cnt + 1;
                if (imem_addr[0]) saw_odd <= 1'b1;
                if (mem_lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_addr);
                end else begin
                    mem_pend   <= 1'b1;
                    mem_cnt    <= mem_lat - 1;
                    mem_addr_l <= imem_addr;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!if_valid && n < max_cyc);
        if (!if_valid) check("wait_if_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_ref;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        imem_req_ready = 1'b1; id_ready = 1'b1; mem_lat = 1; acc_cnt = 0; saw_odd = 1'b0;
        tick(2);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid",  32'(if_valid),       32'd0);
        check("rst_if_instr",  32'(if_instr),       32'h0800);
        check("rst_if_pc",     32'(if_pc),          32'h0000);
        check("rst_halted",    32'(halted),         32'd0);
        check("rst_err",       32'(err),            32'd0);

        // Sequential fetch, 1-cycle memory, decode always ready
        rst_n = 1'b1; #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr",  32'(imem_addr),      32'h0000);
        tick(2);
        check("seq0_valid", 32'(if_valid), 32'd1);
        check("seq0_pc",    32'(if_pc),    32'h0000);
        check("seq0_npc",   32'(if_next_pc), 32'h0002);
        check("seq0_instr", 32'(if_instr), 32'(mem_word(16'h0000)));
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("seq_gap_valid", 32'(if_valid), 32'd0);
            tick(1);
            check("seq_valid", 32'(if_valid),   32'd1);
            check("seq_pc",    32'(if_pc),      32'(2 * k));
            check("seq_npc",   32'(if_next_pc), 32'(2 * k + 2));
            check("seq_instr", 32'(if_instr),   32'(mem_word(16'(2 * k))));
        end

        // Decode stall: buffer held, no new requests
        id_ready = 1'b0; #1;
        acc_ref = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid",   32'(if_valid),       32'd1);
            check("stall_pc",      32'(if_pc),          32'h0006);
            check("stall_instr",   32'(if_instr),       32'(mem_word(16'h0006)));
            check("stall_req",     32'(imem_req_valid), 32'd0);
        end
        check("stall_no_accept", 32'(acc_cnt), 32'(acc_ref));
        id_ready = 1'b1; #1;
        check("unstall_req",  32'(imem_req_valid), 32'd1);
        check("unstall_addr", 32'(imem_addr),      32'h0008);
        tick(1);
        check("unstall_consumed", 32'(if_valid), 32'd0);
        check("unstall_nop",      32'(if_instr), 32'h0800);
        tick(1);
        check("unstall_pc", 32'(if_pc), 32'h0008);

        // Redirect while waiting on a 3-cycle memory
        mem_lat = 3;
        tick(1);
        check("wait_req_low", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick(1);
        redirect_valid = 1'b0;
        check("redir_flush", 32'(if_valid), 32'd0);
        wait_valid(20);
        check("redir_pc",    32'(if_pc),    32'h0100);
        check("redir_instr", 32'(if_instr), 32'(mem_word(16'h0100)));

        // Redirect to top of address space, with a request accepted in the same cycle
        mem_lat = 1;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick(1);
        redirect_valid = 1'b0;
        check("wrap_flush", 32'(if_valid), 32'd0);
        wait_valid(10);
        check("wrap_pc_top",  32'(if_pc),      32'hFFFE);
        check("wrap_npc_top", 32'(if_next_pc), 32'h0000);
        tick(1);
        wait_valid(10);
        check("wrap_pc_zero",  32'(if_pc),      32'h0000);
        check("wrap_npc_zero", 32'(if_next_pc), 32'h0002);

        // Halt while waiting on a response
        mem_lat = 3;
        tick(1);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check("halt_flush",   32'(if_valid), 32'd0);
        check("halt_pending", 32'(halted),   32'd0);
        acc_ref = acc_cnt;
        tick(1);
        check("halt_wait", 32'(halted), 32'd0);
        tick(1);
        check("halt_after_rsp", 32'(halted),   32'd1);
        check("halt_no_word",   32'(if_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick(1);
        redirect_valid = 1'b0;
        tick(4);
        check("halt_sticky",    32'(halted),         32'd1);
        check("halt_no_req",    32'(imem_req_valid), 32'd0);
        check("halt_no_accept", 32'(acc_cnt),        32'(acc_ref));

        // Odd redirect target
        rst_n = 1'b0; mem_lat = 1;
        tick(1);
        check("rst2_halted", 32'(halted),         32'd0);
        check("rst2_req",    32'(imem_req_valid), 32'd0);
        rst_n = 1'b1; #1;
        redirect_valid = 1'b1; redirect_pc = 16'h0011;
        tick(1);
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        tick(3);
        check("align_err",     32'(err),     32'd1);
        check("align_halted",  32'(halted),  32'd1);
        check("align_no_odd",  32'(saw_odd), 32'd0);
        check("align_no_word", 32'(if_valid), 32'd0);
`else
        wait_valid(10);
        check("align_pc",     32'(if_pc),    32'h0010);
        check("align_instr",  32'(if_instr), 32'(mem_word(16'h0010)));
        check("align_err",    32'(err),      32'd0);
        check("align_no_odd", 32'(saw_odd),  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
